seg_display_driver: RTL

Multiplexed four-digit seven-segment driver for the digital clock. It consumes the 6-bit hours and minutes buses from the clock FSM and shows them as HH:MM. It scans one digit at a time, blinks the digits selected by the set-time logic, and flashes the whole display while the alarm sounds. It sits between the clock core and the board pins and is the display-side consumer of the hours/minutes interface.

---
 rtl/seg_display_pkg.sv | 45 ++++
 rtl/seg_display_driver_if.sv | 12 +
 rtl/bin2bcd_6b.sv | 37 +++
 rtl/seg_display_driver.sv | 138 +++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// Segment encodings and digit index constants shared by the display driver.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package seg_display_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Scan order: rightmost digit first
    localparam logic [1:0] MIN_ONES = 2'd0;
    localparam logic [1:0] MIN_TENS = 2'd1;
    localparam logic [1:0] HR_ONES  = 2'd2;
    localparam logic [1:0] HR_TENS  = 2'd3;

    // Decimal digit to segment pattern; anything above 9 is dark
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_display_driver_if.sv
// Time-of-day bus from the clock core plus the blink/alarm controls.
// Latency: none (wires only).
// Backpressure: none; the display samples whenever it needs to.
interface seg_display_driver_if;
    logic [5:0] hours_in;
    logic [5:0] minutes_in;
    logic [3:0] blink_mask;
    logic       alarm_in;

    modport master (output hours_in, output minutes_in, output blink_mask, output alarm_in);
    modport slave  (input  hours_in, input  minutes_in, input  blink_mask, input  alarm_in);
endinterface

// File: rtl/bin2bcd_6b.sv
// Splits a 6-bit binary value into decimal tens/ones and flags values above MAX.
// Latency: combinational.
// Backpressure: not applicable.
module bin2bcd_6b #(
    parameter int unsigned MAX = 59
) (
    input  logic [5:0] bin_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic       in_range_o
);

    logic [5:0] rem;
    logic [3:0] tens;

    // Restoring subtract chain (40, 20, 10) covers the whole 0..63 input range
    always_comb begin
        rem  = bin_i;
        tens = 4'd0;
        if (rem >= 6'd40) begin
            rem  = rem - 6'd40;
            tens = tens + 4'd4;
        end
        if (rem >= 6'd20) begin
            rem  = rem - 6'd20;
            tens = tens + 4'd2;
        end
        if (rem >= 6'd10) begin
            rem  = rem - 6'd10;
            tens = tens + 4'd1;
        end
        tens_o     = tens;
        ones_o     = rem[3:0];
        in_range_o = (32'(bin_i) <= MAX);
    end

endmodule

// File: rtl/seg_display_driver.sv
// Multiplexed four-digit HH:MM seven-segment driver with digit blink and alarm flash.
// Latency: captured frame appears on the pins 1 cycle after capture; blink/alarm act in 1 cycle.
// Backpressure: none; inputs are sampled once per frame and never stalled.
module seg_display_driver
    import seg_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    seg_display_driver_if.slave  disp_if,
    output logic [3:0]           digit_en_n,
    output logic [6:0]           seg_n,
    output logic                 dp_n
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

    // Scan / blink state
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    idx_q, idx_d;
    logic [FW-1:0] frm_q, frm_d;
    logic          phase_q, phase_d;
    logic [5:0]    hr_cap_q, hr_cap_d;
    logic [5:0]    min_cap_q, min_cap_d;

    // Alignment stage: holds idx/phase for one cycle so the first digit of a
    // frame is rendered from the capture taken on that same frame boundary.
    logic          vld_p_q;
    logic [1:0]    idx_p_q;
    logic          phase_p_q;

    // Output registers
    logic [3:0]    en_q, en_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          tick, frame_end, cap_en;
    logic [3:0]    hr_tens, hr_ones, min_tens, min_ones;
    logic          hr_ok, min_ok;
    logic [6:0]    digit_seg;
    logic          blank;

    assign tick      = (pre_q == PRE_LAST);
    assign frame_end = tick && (idx_q == HR_TENS);
    assign cap_en    = (pre_q == '0) && (idx_q == MIN_ONES);

    bin2bcd_6b #(.MAX(23)) u_hr_bcd (
        .bin_i      (hr_cap_q),
        .tens_o     (hr_tens),
        .ones_o     (hr_ones),
        .in_range_o (hr_ok)
    );

    bin2bcd_6b #(.MAX(59)) u_min_bcd (
        .bin_i      (min_cap_q),
        .tens_o     (min_tens),
        .ones_o     (min_ones),
        .in_range_o (min_ok)
    );

    // Next state for prescaler, digit index, frame/blink counters and frame capture
    always_comb begin
        pre_d     = tick ? '0 : pre_q + 1'b1;
        idx_d     = tick ? idx_q + 2'd1 : idx_q;
        frm_d     = frm_q;
        phase_d   = phase_q;
        hr_cap_d  = cap_en ? disp_if.hours_in   : hr_cap_q;
        min_cap_d = cap_en ? disp_if.minutes_in : min_cap_q;
        if (frame_end) begin
            if (frm_q == FRM_LAST) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + 1'b1;
            end
        end
    end

    // Pattern for the digit being shown, with blanking and colon
    always_comb begin
        case (idx_p_q)
            MIN_ONES: digit_seg = min_ok ? seg_encode(min_ones) : SEG_DASH;
            MIN_TENS: digit_seg = min_ok ? seg_encode(min_tens) : SEG_DASH;
            HR_ONES:  digit_seg = hr_ok  ? seg_encode(hr_ones)  : SEG_DASH;
            default:  digit_seg = hr_ok  ? seg_encode(hr_tens)  : SEG_DASH;
        endcase
        blank = phase_p_q && (disp_if.blink_mask[idx_p_q] || disp_if.alarm_in);
        en_d  = 4'b1111;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (vld_p_q) begin
            en_d  = ~(4'b0001 << idx_p_q);
            seg_d = blank ? SEG_BLANK : digit_seg;
            dp_d  = !((idx_p_q == HR_ONES) && !blank);
        end
    end

    // State, alignment stage and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q     <= '0;
            idx_q     <= MIN_ONES;
            frm_q     <= '0;
            phase_q   <= 1'b0;
            hr_cap_q  <= 6'd0;
            min_cap_q <= 6'd0;
            vld_p_q   <= 1'b0;
            idx_p_q   <= MIN_ONES;
            phase_p_q <= 1'b0;
            en_q      <= 4'b1111;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
        end else begin
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            frm_q     <= frm_d;
            phase_q   <= phase_d;
            hr_cap_q  <= hr_cap_d;
            min_cap_q <= min_cap_d;
            vld_p_q   <= 1'b1;
            idx_p_q   <= idx_q;
            phase_p_q <= phase_q;
            en_q      <= en_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign digit_en_n = en_q;
    assign seg_n      = seg_q;
    assign dp_n       = dp_q;

endmodule
